// File: rtl/arm_multicycle_ctl.sv
// Multicycle ARM control FSM: fetch/decode/execute/memory/writeback sequencing, NZCV, sticky fault.
// Optional retired-instruction counter is enabled by defining ARM_CPU_PERF_CNT_EN.
module arm_multicycle_ctl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [3:0]       i_cond,
  input  logic [1:0]       i_op,
  input  logic [5:0]       i_funct,
  input  logic [3:0]       i_rd,
  input  logic [3:0]       i_alu_flags,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_write,
  output logic             o_adr_src,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_reg_write,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_imm_src,
  output logic [2:0]       o_alu_ctl,
  output logic [3:0]       o_nzcv,
  output logic             o_instr_done,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_instr_retired
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExecR, StExecI, StAluWb, StBranch, StFault
  } state_e;

  localparam logic [8:0] TimeoutLim = 9'(MEM_TIMEOUT);

  state_e     r_state, w_state_next;
  logic [3:0] r_nzcv;
  logic [3:0] r_flags;
  logic [7:0] r_wait, w_wait_next;
  logic       w_flags_we, w_nzcv_we;
  logic       w_cond_pass, w_dp_valid, w_is_cmp, w_timeout;
  logic [2:0] w_dp_ctl;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_nzcv;

  always_comb begin
    w_cond_pass = 1'b0;
    case (i_cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = !w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = !w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = !w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = !w_v;
      4'b1000: w_cond_pass = w_c && !w_z;
      4'b1001: w_cond_pass = !w_c || w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = !w_z && (w_n == w_v);
      4'b1101: w_cond_pass = w_z || (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    w_dp_valid = 1'b1;
    w_dp_ctl   = 3'b000;
    case (i_funct[4:1])
      4'b0100: w_dp_ctl = 3'b000;
      4'b0010: w_dp_ctl = 3'b001;
      4'b0000: w_dp_ctl = 3'b010;
      4'b1100: w_dp_ctl = 3'b011;
      4'b1010: w_dp_ctl = 3'b001;
      default: w_dp_valid = 1'b0;
    endcase
  end

  assign w_is_cmp  = (i_funct[4:1] == 4'b1010);
  // Fault lands in the cycle right after the last counted wait cycle.
  assign w_timeout = (({1'b0, r_wait} + 9'd1) >= TimeoutLim);

  always_comb begin
    w_state_next = r_state;
    w_flags_we   = 1'b0;
    w_nzcv_we    = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_result_src = 2'b00;
    o_imm_src    = 2'b00;
    o_alu_ctl    = 3'b000;
    o_instr_done = 1'b0;
    o_fault      = 1'b0;
    // Outputs are held quiet for the whole reset so an in-flight access is dropped at once.
    if (!i_reset) begin
      unique case (r_state)
        StFetch: begin
          o_mem_req    = 1'b1;
          o_alu_src_a  = 2'b01;
          o_alu_src_b  = 2'b10;
          o_result_src = 2'b10;
          if (i_mem_ready) begin
            o_ir_write   = 1'b1;
            o_pc_write   = 1'b1;
            w_state_next = StDecode;
          end else if (w_timeout) begin
            w_state_next = StFault;
          end
        end
        StDecode: begin
          o_alu_src_a  = 2'b01;
          o_alu_src_b  = 2'b10;
          o_result_src = 2'b10;
          if (!w_cond_pass) begin
            o_instr_done = 1'b1;
            w_state_next = StFetch;
          end else if (i_op == 2'b00) begin
            if (!w_dp_valid)     w_state_next = StFault;
            else if (i_funct[5]) w_state_next = StExecI;
            else                 w_state_next = StExecR;
          end else if (i_op == 2'b01 && !i_funct[5]) begin
            w_state_next = StMemAdr;
          end else if (i_op == 2'b10 && !i_funct[4]) begin
            w_state_next = StBranch;
          end else begin
            w_state_next = StFault;
          end
        end
        StExecR, StExecI: begin
          o_alu_src_b  = (r_state == StExecI) ? 2'b01 : 2'b00;
          o_alu_ctl    = w_dp_ctl;
          w_flags_we   = 1'b1;
          w_state_next = StAluWb;
        end
        StAluWb: begin
          if (!w_is_cmp) begin
            if (i_rd == 4'd15) o_pc_write  = 1'b1;
            else               o_reg_write = 1'b1;
          end
          w_nzcv_we    = i_funct[0] || w_is_cmp;
          o_instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StMemAdr: begin
          o_alu_src_b  = 2'b01;
          o_imm_src    = 2'b01;
          o_alu_ctl    = i_funct[3] ? 3'b000 : 3'b001;
          w_state_next = i_funct[0] ? StMemRd : StMemWr;
        end
        StMemRd, StMemWr: begin
          o_mem_req   = 1'b1;
          o_adr_src   = 1'b1;
          o_mem_write = (r_state == StMemWr);
          if (i_mem_ready) begin
            if (r_state == StMemWr) begin
              o_instr_done = 1'b1;
              w_state_next = StFetch;
            end else begin
              w_state_next = StMemWb;
            end
          end else if (w_timeout) begin
            w_state_next = StFault;
          end
        end
        StMemWb: begin
          o_result_src = 2'b01;
          if (i_rd == 4'd15) o_pc_write  = 1'b1;
          else               o_reg_write = 1'b1;
          o_instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StBranch: begin
          o_alu_src_b  = 2'b01;
          o_imm_src    = 2'b10;
          o_result_src = 2'b10;
          o_pc_write   = 1'b1;
          o_instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StFault: o_fault = 1'b1;
        default: w_state_next = StFault;
      endcase
    end
  end

  assign w_wait_next = (o_mem_req && !i_mem_ready && (w_state_next == r_state)) ?
                       r_wait + 8'd1 : 8'd0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StFetch;
      r_nzcv  <= 4'b0000;
      r_flags <= 4'b0000;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (w_flags_we) r_flags <= i_alu_flags;
      if (w_nzcv_we)  r_nzcv  <= r_flags;
    end
  end

  assign o_nzcv = r_nzcv;

`ifdef ARM_CPU_PERF_CNT_EN
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_retired <= '0;
    end else if (o_instr_done && r_state != StFault) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_instr_retired = r_retired;
`else
  assign o_instr_retired = '0;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctl.sv
// Scoreboard bench: each stimulus cycle queues the expected control word; a negedge monitor checks it.
module tb_arm_multicycle_ctl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;

  bit          clk;
  logic        rst;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]  alu_ctl;
  logic [3:0]  nzcv;
  logic        instr_done, fault;
  logic [CntW-1:0] instr_retired;

  typedef struct packed {
    logic [3:0] ret;
    logic       fault;
    logic       done;
    logic [3:0] nzcv;
    logic [2:0] alu_ctl;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_src_a;
    logic       reg_write;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       mem_req;
  } exp_t;

  exp_t       expq[$];
  string      tagq[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_nzcv;
  logic [3:0] exp_ret;

  always #5 clk = ~clk;

  arm_multicycle_ctl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) u_dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cond         (cond),
    .i_op           (op),
    .i_funct        (funct),
    .i_rd           (rd),
    .i_alu_flags    (alu_flags),
    .i_mem_ready    (mem_ready),
    .o_mem_req      (mem_req),
    .o_mem_write    (mem_write),
    .o_adr_src      (adr_src),
    .o_ir_write     (ir_write),
    .o_pc_write     (pc_write),
    .o_reg_write    (reg_write),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_result_src   (result_src),
    .o_imm_src      (imm_src),
    .o_alu_ctl      (alu_ctl),
    .o_nzcv         (nzcv),
    .o_instr_done   (instr_done),
    .o_fault        (fault),
    .o_instr_retired(instr_retired)
  );

  // Monitor: one queued expectation per clock cycle, sampled mid-cycle.
  initial begin
    exp_t  e;
    exp_t  got;
    string t;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        got = '{ret: instr_retired, fault: fault, done: instr_done, nzcv: nzcv,
                alu_ctl: alu_ctl, imm_src: imm_src, result_src: result_src,
                alu_src_b: alu_src_b, alu_src_a: alu_src_a, reg_write: reg_write,
                pc_write: pc_write, ir_write: ir_write, adr_src: adr_src,
                mem_write: mem_write, mem_req: mem_req};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s at %0t: got=%h expected=%h", t, $time, got, e);
        end
      end
    end
  end

  function automatic exp_t f_base();
    exp_t e;
    e      = '0;
    e.nzcv = exp_nzcv;
    e.ret  = exp_ret;
    return e;
  endfunction

  function automatic exp_t f_fetch(input logic rdy);
    exp_t e = f_base();
    e.mem_req    = 1'b1;
    e.alu_src_a  = 2'b01;
    e.alu_src_b  = 2'b10;
    e.result_src = 2'b10;
    e.ir_write   = rdy;
    e.pc_write   = rdy;
    return e;
  endfunction

  function automatic exp_t f_decode(input logic skip);
    exp_t e = f_base();
    e.alu_src_a  = 2'b01;
    e.alu_src_b  = 2'b10;
    e.result_src = 2'b10;
    e.done       = skip;
    return e;
  endfunction

  function automatic exp_t f_exec(input logic imm, input logic [2:0] ctl);
    exp_t e = f_base();
    e.alu_src_b = imm ? 2'b01 : 2'b00;
    e.alu_ctl   = ctl;
    return e;
  endfunction

  function automatic exp_t f_aluwb(input logic rw, input logic pw);
    exp_t e = f_base();
    e.reg_write = rw;
    e.pc_write  = pw;
    e.done      = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_memadr(input logic [2:0] ctl);
    exp_t e = f_base();
    e.alu_src_b = 2'b01;
    e.imm_src   = 2'b01;
    e.alu_ctl   = ctl;
    return e;
  endfunction

  function automatic exp_t f_memacc(input logic wr, input logic rdy);
    exp_t e = f_base();
    e.mem_req   = 1'b1;
    e.adr_src   = 1'b1;
    e.mem_write = wr;
    e.done      = wr & rdy;
    return e;
  endfunction

  function automatic exp_t f_memwb(input logic to_pc);
    exp_t e = f_base();
    e.result_src = 2'b01;
    e.pc_write   = to_pc;
    e.reg_write  = !to_pc;
    e.done       = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_branch();
    exp_t e = f_base();
    e.alu_src_b  = 2'b01;
    e.imm_src    = 2'b10;
    e.result_src = 2'b10;
    e.pc_write   = 1'b1;
    e.done       = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_fault();
    exp_t e = f_base();
    e.fault = 1'b1;
    return e;
  endfunction

  task automatic cyc(input string tag, input exp_t e, input logic rdy);
    mem_ready = rdy;
    expq.push_back(e);
    tagq.push_back(tag);
`ifdef ARM_CPU_PERF_CNT_EN
    if (e.done) exp_ret = exp_ret + 4'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    exp_nzcv = 4'b0000;
    exp_ret  = 4'd0;
    for (int i = 0; i < n; i++) cyc("reset", exp_t'(0), 1'b1);
    rst = 1'b0;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r);
    cond  = c;
    op    = o;
    funct = f;
    rd    = r;
  endtask

  initial begin
    rst       = 1'b1;
    cond      = 4'b1110;
    op        = 2'b00;
    funct     = 6'b000000;
    rd        = 4'd0;
    alu_flags = 4'b0000;
    mem_ready = 1'b0;
    exp_nzcv  = 4'b0000;
    exp_ret   = 4'd0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Fetch never acknowledged: fault after exactly MemTimeout wait cycles, ready then ignored.
    for (int i = 0; i < 4; i++) cyc("fetch_timeout_wait", f_fetch(1'b0), 1'b0);
    for (int i = 0; i < 3; i++) cyc("fault_sticky", f_fault(), 1'b1);
    do_reset(1);

    // op = 11 is undefined.
    cyc("fetch_op11", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b11, 6'b000000, 4'd1);
    cyc("decode_op11", f_decode(1'b0), 1'b1);
    for (int i = 0; i < 2; i++) cyc("fault_op11", f_fault(), 1'b1);
    do_reset(1);

    // EOR opcode is not supported.
    cyc("fetch_eor", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b00, 6'b000010, 4'd2);
    cyc("decode_eor", f_decode(1'b0), 1'b1);
    cyc("fault_eor", f_fault(), 1'b1);
    do_reset(1);

    // BL is not supported.
    cyc("fetch_bl", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b10, 6'b110000, 4'd0);
    cyc("decode_bl", f_decode(1'b0), 1'b1);
    cyc("fault_bl", f_fault(), 1'b1);
    do_reset(1);

    // Store interrupted by reset while waiting.
    cyc("fetch_str_abort", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd4);
    cyc("decode_str_abort", f_decode(1'b0), 1'b1);
    cyc("memadr_str_abort", f_memadr(3'b000), 1'b1);
    cyc("memwr_wait_abort", f_memacc(1'b1, 1'b0), 1'b0);
    do_reset(2);

    // Fetch with MemTimeout-1 wait cycles must not fault.
    for (int i = 0; i < 3; i++) cyc("fetch_wait3", f_fetch(1'b0), 1'b0);
    cyc("fetch_wait3_done", f_fetch(1'b1), 1'b1);

    // ADD r1 (register, S=0): flags untouched.
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
    cyc("decode_add", f_decode(1'b0), 1'b1);
    alu_flags = 4'b1111;
    cyc("execr_add", f_exec(1'b0, 3'b000), 1'b1);
    cyc("aluwb_add", f_aluwb(1'b1, 1'b0), 1'b1);

    // SUBS r2: flags latched in EXEC (0100), ALU flags differ during writeback.
    cyc("fetch_subs", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b00, 6'b000101, 4'd2);
    cyc("decode_subs", f_decode(1'b0), 1'b1);
    alu_flags = 4'b0100;
    cyc("execr_subs", f_exec(1'b0, 3'b001), 1'b1);
    alu_flags = 4'b1011;
    cyc("aluwb_subs", f_aluwb(1'b1, 1'b0), 1'b1);
    exp_nzcv = 4'b0100;

    // BEQ taken.
    cyc("fetch_beq", f_fetch(1'b1), 1'b1);
    set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
    cyc("decode_beq", f_decode(1'b0), 1'b1);
    cyc("branch_beq", f_branch(), 1'b1);

    // ORRNE skipped in decode.
    cyc("fetch_orrne", f_fetch(1'b1), 1'b1);
    set_instr(4'b0001, 2'b00, 6'b011000, 4'd3);
    cyc("decode_orrne_skip", f_decode(1'b1), 1'b1);

    // CMP immediate with S bit clear still updates flags, never writes back.
    cyc("fetch_cmp", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b00, 6'b110100, 4'd0);
    cyc("decode_cmp", f_decode(1'b0), 1'b1);
    alu_flags = 4'b1000;
    cyc("execi_cmp", f_exec(1'b1, 3'b001), 1'b1);
    alu_flags = 4'b0111;
    cyc("aluwb_cmp", f_aluwb(1'b0, 1'b0), 1'b1);
    exp_nzcv = 4'b1000;

    // ADDLT imm to r15 (N != V passes): pc_write instead of reg_write.
    cyc("fetch_addpc", f_fetch(1'b1), 1'b1);
    set_instr(4'b1011, 2'b00, 6'b101000, 4'd15);
    cyc("decode_addpc", f_decode(1'b0), 1'b1);
    alu_flags = 4'b0001;
    cyc("execi_addpc", f_exec(1'b1, 3'b000), 1'b1);
    cyc("aluwb_addpc", f_aluwb(1'b0, 1'b1), 1'b1);

    // ORRS r5 register.
    cyc("fetch_orrs", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b00, 6'b011001, 4'd5);
    cyc("decode_orrs", f_decode(1'b0), 1'b1);
    alu_flags = 4'b0010;
    cyc("execr_orrs", f_exec(1'b0, 3'b011), 1'b1);
    cyc("aluwb_orrs", f_aluwb(1'b1, 1'b0), 1'b1);
    exp_nzcv = 4'b0010;

    // AND r6 immediate.
    cyc("fetch_and", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b00, 6'b100000, 4'd6);
    cyc("decode_and", f_decode(1'b0), 1'b1);
    cyc("execi_and", f_exec(1'b1, 3'b010), 1'b1);
    cyc("aluwb_and", f_aluwb(1'b1, 1'b0), 1'b1);

    // LDR r3 with three wait cycles.
    cyc("fetch_ldr", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd3);
    cyc("decode_ldr", f_decode(1'b0), 1'b1);
    cyc("memadr_ldr", f_memadr(3'b000), 1'b1);
    for (int i = 0; i < 3; i++) cyc("memrd_wait", f_memacc(1'b0, 1'b0), 1'b0);
    cyc("memrd_ready", f_memacc(1'b0, 1'b1), 1'b1);
    cyc("memwb_ldr", f_memwb(1'b0), 1'b1);

    // LDR pc, down-indexed.
    cyc("fetch_ldrpc", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b01, 6'b010001, 4'd15);
    cyc("decode_ldrpc", f_decode(1'b0), 1'b1);
    cyc("memadr_ldrpc", f_memadr(3'b001), 1'b1);
    cyc("memrd_ldrpc", f_memacc(1'b0, 1'b1), 1'b1);
    cyc("memwb_ldrpc", f_memwb(1'b1), 1'b1);

    // STR with one wait cycle.
    cyc("fetch_str", f_fetch(1'b1), 1'b1);
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd4);
    cyc("decode_str", f_decode(1'b0), 1'b1);
    cyc("memadr_str", f_memadr(3'b000), 1'b1);
    cyc("memwr_wait", f_memacc(1'b1, 1'b0), 1'b0);
    cyc("memwr_ready", f_memacc(1'b1, 1'b1), 1'b1);

    // CC with C=1 fails; then NV (even with op=11) never executes nor faults.
    cyc("fetch_cc", f_fetch(1'b1), 1'b1);
    set_instr(4'b0011, 2'b00, 6'b001000, 4'd7);
    cyc("decode_cc_skip", f_decode(1'b1), 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc("fetch_nv", f_fetch(1'b1), 1'b1);
      set_instr(4'b1111, 2'b11, 6'b000000, 4'd8);
      cyc("decode_nv_skip", f_decode(1'b1), 1'b1);
    end
    // Seventeenth retirement is visible here (counter wraps when enabled).
    cyc("fetch_final", f_fetch(1'b0), 1'b0);

    for (int i = 0; i < 4 && expq.size() != 0; i++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_multicycle_ctl.md
Name: arm_multicycle_ctl

Overview:
- Control unit for the next-generation multicycle ARM core: one unified instruction/data memory port with a variable-latency ready handshake.
- Replaces the single-cycle decoder with an FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Holds the architectural NZCV register and evaluates condition codes.
- Detects undefined encodings and memory timeouts and raises a sticky fault.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles per memory request before fault; range 1..255.
- CNT_W, 32: width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cond  in  4  instr[31:28] from the instruction register
- op  in  2  instr[27:26]
- funct  in  6  instr[25:20]
- rd  in  4  instr[15:12]
- alu_flags  in  4  NZCV from the ALU this cycle
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load the instruction register
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = reg A, 01 = PC, 10 = ALU out
- alu_src_b  out  2  00 = reg B, 01 = extended immediate, 10 = constant 4
- result_src  out  2  00 = ALU out register, 01 = data register, 10 = ALU direct
- imm_src  out  2  00 = imm8 (DP), 01 = imm12 (mem), 10 = imm24 (branch)
- alu_ctl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- nzcv  out  4  architectural flags
- instr_done  out  1  one-cycle pulse when an instruction retires
- fault  out  1  sticky fault indicator
- instr_retired  out  CNT_W  retired-instruction count (optional feature)

Behaviour:
- Reset: state = FETCH, nzcv = 0, fault = 0, wait counter = 0, instr_retired = 0. All enables and strobes are 0; mux selects are 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- FETCH: mem_req = 1, adr_src = 0, alu_src_a = 01, alu_src_b = 10, result_src = 10.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1; then go to DECODE.
- DECODE: computes PC+8 with the same selects as FETCH; no enables asserted. Evaluates cond against nzcv (EQ..AL; 1111 is treated as never). Transitions:
  - cond fails: instr_done = 1, go to FETCH.
  - op = 00, funct[5] = 1: EXECI.
  - op = 00, funct[5] = 0: EXECR.
  - op = 01, funct[5] = 0: MEMADR.
  - op = 10, funct[4] = 0: BRANCH.
  - Anything else (op = 11, register-offset memory, BL): FAULT.
- DP opcode funct[4:1]: 0100 ADD→000, 0010 SUB→001, 0000 AND→010, 1100 ORR→011, 1010 CMP→001. Any other code → FAULT, decided in DECODE.
- EXECR/EXECI: alu_src_a = 00; alu_src_b = 00 (R) or 01 (I) with imm_src = 00. Next state ALUWB.
- ALUWB: result_src = 00. Commits writeback and flags, then instr_done = 1, go to FETCH.
  - Writeback: rd = 15 → pc_write = 1, otherwise reg_write = 1. CMP never writes back.
  - Flags: nzcv <= alu_flags (as latched from EXEC) if funct[0] = 1 or opcode is CMP.
- MEMADR: alu_src_a = 00, alu_src_b = 01, imm_src = 01, alu_ctl = 000 if funct[3] = 1 else 001. Next state MEMRD if funct[0] = 1, else MEMWR.
- MEMRD/MEMWR: mem_req = 1, adr_src = 1, mem_write = 1 in MEMWR.
  - Hold until mem_ready = 1.
  - MEMRD then goes to MEMWB.
  - MEMWR then pulses instr_done and goes to FETCH.
- MEMWB: result_src = 01. rd = 15 → pc_write = 1, otherwise reg_write = 1. instr_done = 1, go to FETCH.
- BRANCH: alu_src_a = 00, alu_src_b = 01, imm_src = 10, alu_ctl = 000, result_src = 10, pc_write = 1. instr_done = 1, go to FETCH.
- Wait counter:
  - Cleared on entry to any memory state and on mem_ready.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - Reaching MEM_TIMEOUT → FAULT the next cycle, with no strobes issued for the aborted access.
- FAULT: fault = 1, all strobes 0, state held until reset. mem_ready is ignored.
- Reset asserted mid-access drops mem_req asynchronously. A pending write is not committed.
- mem_ready = 1 outside a memory state is ignored.
- Flags change only in ALUWB.

Optional Feature:
- Macro ARM_CPU_PERF_CNT_EN.
- When defined: instr_retired increments on every instr_done pulse, including cond-failed instructions, and wraps modulo 2^CNT_W. It is frozen in FAULT.
- When undefined: instr_retired is tied to 0 and no counter flops exist.

Test Plan:
- ADD r1 (E0811002 class, S = 0), mem_ready tied 1 → FETCH, DECODE, EXECR, ALUWB; reg_write in cycle 4; instr_done at cycle 4; nzcv unchanged.
- SUBS with alu_flags = 0100 followed by BEQ → nzcv = 0100 after ALUWB; branch taken, pc_write in BRANCH; ORRNE following is skipped with instr_done in DECODE.
- LDR with mem_ready delayed 3 cycles in MEMRD → mem_req held 4 cycles with adr_src = 1; reg_write in MEMWB; LDR to rd = 15 asserts pc_write instead.
- MEM_TIMEOUT = 4, mem_ready stuck 0 in FETCH → fault = 1 after 4 wait cycles; ir_write never asserted; only reset clears fault.
- op = 11 instruction → DECODE goes to FAULT; no reg_write, pc_write or mem_req afterwards.
- With ARM_CPU_PERF_CNT_EN and CNT_W = 4: run 17 instructions → instr_retired = 1 (wrap); without the macro it stays 0.
